// File: rtl/hs_dpath_pkg.sv
//----------------------------------------------------------------------------
// hs_dpath_pkg
//
// Purpose : Shared declarations for the elastic tapped shift register family.
//           Provides the latency ceiling, the occupancy-counter width helper
//           and the transfer-kind encoding used by the optional occupancy
//           counter (HS_DPATH_SFR_OCC_CNT_EN).
// Ports   : none (package).
//----------------------------------------------------------------------------
package hs_dpath_pkg;

    // Largest supported number of stages.
    localparam int HS_DPATH_SFR_MAX_LATENCY = 1024;

    // Bits needed to count 0..latency valid stages.
    function automatic int hs_dpath_occ_width(input int latency);
        return $clog2(latency + 1);
    endfunction

    // Handshake activity in one cycle, encoded as {input_xfer, output_xfer}.
    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_OUT  = 2'b01,
        XFER_IN   = 2'b10,
        XFER_BOTH = 2'b11
    } hs_dpath_xfer_e;

endpackage : hs_dpath_pkg

// File: rtl/hs_dpath_sfr_elastic_tap_if.sv
//----------------------------------------------------------------------------
// hs_dpath_sfr_elastic_tap_if
//
// Purpose : One valid/ready/data handshake link carrying CHANNELS lanes of
//           DATA_TYPE. The same interface describes both the upstream and
//           the downstream side of the elastic shift register.
// Signals : valid - source holds a beat
//           ready - sink accepts this cycle
//           data  - CHANNELS x DATA_TYPE payload
// Modports: master - drives valid/data, receives ready
//           slave  - receives valid/data, drives ready
//----------------------------------------------------------------------------
interface hs_dpath_sfr_elastic_tap_if #(
    parameter type DATA_TYPE = logic,
    parameter int  CHANNELS  = 1
);

    logic                       valid;
    logic                       ready;
    DATA_TYPE [CHANNELS-1:0]    data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface : hs_dpath_sfr_elastic_tap_if

// File: rtl/hs_dpath_sfr_elastic_stage.sv
//----------------------------------------------------------------------------
// hs_dpath_sfr_elastic_stage
//
// Purpose : One stage of the elastic shift register. When the stage is
//           allowed to advance it takes the upstream valid; its payload is
//           only overwritten by a real beat, so bubbles leave data stable.
//           flush clears the valid without touching the payload.
// Ports   : clk      - clock, rising edge
//           sreset   - synchronous active-high reset (highest priority)
//           flush    - synchronous clear of the stage valid
//           up_valid - valid of the feeding stage (or masked s_valid)
//           up_data  - payload of the feeding stage (or s_data)
//           adv      - stage may load from upstream this cycle
//           vld      - stage holds a beat
//           dat      - stage payload
//----------------------------------------------------------------------------
module hs_dpath_sfr_elastic_stage
    import hs_dpath_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0,
    parameter int       CHANNELS    = 1
) (
    input  logic                    clk,
    input  logic                    sreset,
    input  logic                    flush,
    input  logic                    up_valid,
    input  DATA_TYPE [CHANNELS-1:0] up_data,
    input  logic                    adv,
    output logic                    vld,
    output DATA_TYPE [CHANNELS-1:0] dat
);

    logic                    vld_q, vld_d;
    DATA_TYPE [CHANNELS-1:0] dat_q, dat_d;

    // NOTE: every always_comb output gets a hold default first, so no path
    //       leaves it unassigned and no latch is inferred.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (adv) begin
            vld_d = up_valid;
            if (up_valid) begin
                dat_d = up_data;
            end
        end
    end

    // NOTE: state is written with non-blocking assignments only, so every
    //       stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (sreset) begin
            vld_q <= 1'b0;
            // NOTE: the payload is reset too, because the taps expose it
            //       and must read RESET_VALUE right after reset.
            for (int c = 0; c < CHANNELS; c++) begin
                dat_q[c] <= RESET_VALUE;
            end
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld = vld_q;
    assign dat = dat_q;

endmodule : hs_dpath_sfr_elastic_stage

// File: rtl/hs_dpath_sfr_elastic_tap.sv
//----------------------------------------------------------------------------
// hs_dpath_sfr_elastic_tap
//
// Purpose : Parametrised elastic shift register with LATENCY stages,
//           valid/ready handshake on both ends, bubble collapsing and
//           per-stage taps. With m_ready held high a beat accepted in
//           cycle t leaves at cycle t+LATENCY; under backpressure empty
//           stages keep filling until all LATENCY stages hold a beat.
// Ports   : clk       - clock, rising edge
//           sreset    - synchronous active-high reset, drops all beats
//           flush     - clears every stage valid next cycle, payloads kept
//           s_if      - upstream link (slave): s_valid / s_ready / s_data
//           m_if      - downstream link (master): m_valid / m_ready / m_data
//           tap_valid - per-stage valid, bit LATENCY-1 is the output stage
//           tap_data  - per-stage payload, entry LATENCY-1 is m_data
//           occ_cnt   - number of valid stages (HS_DPATH_SFR_OCC_CNT_EN only)
// Config  : define HS_DPATH_SFR_OCC_CNT_EN to add the occ_cnt output and its
//           consistency assertion against tap_valid.
// Timing  : the ready/advance path is combinational across all stages.
//----------------------------------------------------------------------------
module hs_dpath_sfr_elastic_tap
    import hs_dpath_pkg::*;
#(
    parameter type      DATA_TYPE   = logic,
    parameter DATA_TYPE RESET_VALUE = '0,
    parameter int       LATENCY     = 2,
    parameter int       CHANNELS    = 1
) (
    input  logic                                  clk,
    input  logic                                  sreset,
    input  logic                                  flush,
    hs_dpath_sfr_elastic_tap_if.slave             s_if,
    hs_dpath_sfr_elastic_tap_if.master            m_if,
    output logic [LATENCY-1:0]                    tap_valid,
    output DATA_TYPE [LATENCY-1:0][CHANNELS-1:0]  tap_data
`ifdef HS_DPATH_SFR_OCC_CNT_EN
    ,
    output logic [hs_dpath_occ_width(LATENCY)-1:0] occ_cnt
`endif
);

    logic [LATENCY-1:0]                   vld;
    logic [LATENCY-1:0]                   adv;
    logic [LATENCY-1:0]                   up_vld;
    DATA_TYPE [LATENCY-1:0][CHANNELS-1:0] up_dat;
    DATA_TYPE [LATENCY-1:0][CHANNELS-1:0] dat;
    logic                                 s_ready;

    // The recursive chain adv[i] = !vld[i] | adv[i+1] with
    // adv[LATENCY-1] = !vld[LATENCY-1] | m_ready unrolls to: a stage may
    // advance when downstream is ready or any stage from i to the output is
    // empty. Written flat so no signal feeds back into its own vector.
    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        assign adv[i] = m_if.ready | ~(&vld[LATENCY-1:i]);

        if (i == 0) begin : g_head
            // flush forces s_ready low, so the head stage must not take the
            // offered beat either.
            assign up_vld[i] = s_if.valid & ~flush;
            assign up_dat[i] = s_if.data;
        end else begin : g_body
            assign up_vld[i] = vld[i-1];
            assign up_dat[i] = dat[i-1];
        end

        hs_dpath_sfr_elastic_stage #(
            .DATA_TYPE   (DATA_TYPE),
            .RESET_VALUE (RESET_VALUE),
            .CHANNELS    (CHANNELS)
        ) u_stage (
            .clk      (clk),
            .sreset   (sreset),
            .flush    (flush),
            .up_valid (up_vld[i]),
            .up_data  (up_dat[i]),
            .adv      (adv[i]),
            .vld      (vld[i]),
            .dat      (dat[i])
        );
    end

    assign s_ready     = adv[0] & ~flush;
    assign s_if.ready  = s_ready;
    assign m_if.valid  = vld[LATENCY-1];
    assign m_if.data   = dat[LATENCY-1];
    assign tap_valid   = vld;
    assign tap_data    = dat;

`ifdef HS_DPATH_SFR_OCC_CNT_EN
    localparam int OCC_W = hs_dpath_occ_width(LATENCY);

    logic [OCC_W-1:0] occ_cnt_q, occ_cnt_d;
    hs_dpath_xfer_e   xfer;

    // Internal moves conserve the beat count; only the two ends change it.
    always_comb begin
        xfer      = hs_dpath_xfer_e'({s_if.valid & s_ready,
                                      m_if.valid & m_if.ready});
        occ_cnt_d = occ_cnt_q;
        if (flush) begin
            occ_cnt_d = '0;
        end else begin
            case (xfer)
                XFER_IN:  occ_cnt_d = occ_cnt_q + OCC_W'(1);
                XFER_OUT: occ_cnt_d = occ_cnt_q - OCC_W'(1);
                default:  occ_cnt_d = occ_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            occ_cnt_q <= '0;
        end else begin
            occ_cnt_q <= occ_cnt_d;
        end
    end

    assign occ_cnt = occ_cnt_q;

    a_occ_matches_taps : assert property (
        @(posedge clk) disable iff (sreset)
        occ_cnt_q == OCC_W'($countones(vld))
    );
`endif

endmodule : hs_dpath_sfr_elastic_tap

// File: tb/tb_hs_dpath_sfr_elastic_tap.sv
//----------------------------------------------------------------------------
// tb_hs_dpath_sfr_elastic_tap
//
// Directed bench for hs_dpath_sfr_elastic_tap. Two instances: LATENCY=4
// (reset, streaming, backpressure, bubble collapse, flush) and LATENCY=1
// (ready toggling, reset mid-stream). Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
//----------------------------------------------------------------------------
module tb_hs_dpath_sfr_elastic_tap;
    import hs_dpath_pkg::*;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sreset;
    logic flush4;
    logic flush1;

    hs_dpath_sfr_elastic_tap_if #(.DATA_TYPE(byte_t), .CHANNELS(1)) s4_if ();
    hs_dpath_sfr_elastic_tap_if #(.DATA_TYPE(byte_t), .CHANNELS(1)) m4_if ();
    hs_dpath_sfr_elastic_tap_if #(.DATA_TYPE(byte_t), .CHANNELS(1)) s1_if ();
    hs_dpath_sfr_elastic_tap_if #(.DATA_TYPE(byte_t), .CHANNELS(1)) m1_if ();

    logic [3:0]          tap4_valid;
    byte_t [3:0][0:0]    tap4_data;
    logic [0:0]          tap1_valid;
    byte_t [0:0][0:0]    tap1_data;
`ifdef HS_DPATH_SFR_OCC_CNT_EN
    logic [hs_dpath_occ_width(4)-1:0] occ4;
    logic [hs_dpath_occ_width(1)-1:0] occ1;
`endif

    hs_dpath_sfr_elastic_tap #(
        .DATA_TYPE   (byte_t),
        .RESET_VALUE (8'hA5),
        .LATENCY     (4),
        .CHANNELS    (1)
    ) u_dut4 (
        .clk       (clk),
        .sreset    (sreset),
        .flush     (flush4),
        .s_if      (s4_if),
        .m_if      (m4_if),
        .tap_valid (tap4_valid),
        .tap_data  (tap4_data)
`ifdef HS_DPATH_SFR_OCC_CNT_EN
        ,
        .occ_cnt   (occ4)
`endif
    );

    hs_dpath_sfr_elastic_tap #(
        .DATA_TYPE   (byte_t),
        .RESET_VALUE (8'h3C),
        .LATENCY     (1),
        .CHANNELS    (1)
    ) u_dut1 (
        .clk       (clk),
        .sreset    (sreset),
        .flush     (flush1),
        .s_if      (s1_if),
        .m_if      (m1_if),
        .tap_valid (tap1_valid),
        .tap_data  (tap1_data)
`ifdef HS_DPATH_SFR_OCC_CNT_EN
        ,
        .occ_cnt   (occ1)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Hard bound on run time in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    n_in;
        int    n_out;
        logic  [2:0] mr_seq;
        byte_t d_seq [3];

        sreset       = 1'b1;
        flush4       = 1'b0;
        flush1       = 1'b0;
        s4_if.valid  = 1'b0;
        s4_if.data   = '0;
        m4_if.ready  = 1'b0;
        s1_if.valid  = 1'b0;
        s1_if.data   = '0;
        m1_if.ready  = 1'b0;

        // ---------------- reset: two cycles ----------------
        next_cycle();
        next_cycle();
        sreset = 1'b0;
        mid();
        check("rst4_m_valid",   32'(m4_if.valid), 0);
        check("rst4_tap_valid", 32'(tap4_valid),  0);
        check("rst4_s_ready",   32'(s4_if.ready), 1);
        check("rst4_tap_data",  32'(tap4_data),   32'hA5A5A5A5);
        check("rst1_m_valid",   32'(m1_if.valid), 0);
        check("rst1_s_ready",   32'(s1_if.ready), 1);
        check("rst1_tap_data",  32'(tap1_data),   32'h3C);
`ifdef HS_DPATH_SFR_OCC_CNT_EN
        check("rst4_occ", 32'(occ4), 0);
        check("rst1_occ", 32'(occ1), 0);
`endif
        next_cycle();

        // ---------------- streaming 0x01..0x10 ----------------
        for (int k = 0; k < 26; k++) begin
            s4_if.valid = (k < 16);
            s4_if.data  = byte_t'(k + 1);
            m4_if.ready = 1'b1;
            mid();
            if (k < 16) check("str_s_ready", 32'(s4_if.ready), 1);
            check("str_m_valid", 32'(m4_if.valid), 32'(k >= 4 && k < 20));
            if (k >= 4 && k < 20) check("str_m_data", 32'(m4_if.data), 32'(k - 3));
            next_cycle();
        end
        s4_if.valid = 1'b0;
        mid();
        check("empty_m_valid",   32'(m4_if.valid), 0);
        check("empty_m_data_kept", 32'(m4_if.data), 32'h10);
        next_cycle();

        // ---------------- backpressure: 6 beats, m_ready low ----------------
        for (int k = 0; k < 6; k++) begin
            s4_if.valid = 1'b1;
            s4_if.data  = (k < 4) ? byte_t'(8'h21 + k) : 8'h25;
            m4_if.ready = 1'b0;
            mid();
            check("bp_s_ready", 32'(s4_if.ready), 32'(k < 4));
            if (k == 5) begin
                check("bp_full_tap_valid", 32'(tap4_valid), 32'hF);
                check("bp_full_tap_data",  32'(tap4_data),  32'h21222324);
                check("bp_full_m_data",    32'(m4_if.data), 32'h21);
`ifdef HS_DPATH_SFR_OCC_CNT_EN
                check("bp_occ_peak", 32'(occ4), 4);
`endif
            end
            next_cycle();
        end
        for (int j = 0; j < 7; j++) begin
            m4_if.ready = 1'b1;
            s4_if.valid = (j < 2);
            s4_if.data  = byte_t'(8'h25 + j);
            mid();
            if (j < 2) check("drain_s_ready", 32'(s4_if.ready), 1);
            check("drain_m_valid", 32'(m4_if.valid), 32'(j < 6));
            if (j < 6) check("drain_m_data", 32'(m4_if.data), 32'(8'h21 + j));
            next_cycle();
        end

        // ---------------- bubble collapse ----------------
        for (int b = 0; b < 6; b++) begin
            s4_if.valid = (b == 0 || b == 2);
            s4_if.data  = (b == 0) ? 8'h31 : 8'h32;
            m4_if.ready = (b < 3);
            mid();
            if (b == 4) check("bub_tap_valid_c4", 32'(tap4_valid), 32'b1010);
            if (b == 5) begin
                check("bub_tap_valid_c5", 32'(tap4_valid), 32'b1100);
                check("bub_tap_data_c5",  32'(tap4_data),  32'h31323232);
                check("bub_m_valid",      32'(m4_if.valid), 1);
                check("bub_m_data",       32'(m4_if.data),  32'h31);
            end
            next_cycle();
        end

        // ---------------- flush with three beats in flight ----------------
        s4_if.valid = 1'b1;
        s4_if.data  = 8'h33;
        m4_if.ready = 1'b0;
        mid();
        check("fl_pre_s_ready", 32'(s4_if.ready), 1);
        next_cycle();
        flush4      = 1'b1;
        s4_if.valid = 1'b1;
        s4_if.data  = 8'h44;
        m4_if.ready = 1'b1;
        mid();
        check("fl_s_ready",   32'(s4_if.ready), 0);
        check("fl_m_valid",   32'(m4_if.valid), 1);
        check("fl_m_data",    32'(m4_if.data),  32'h31);
        check("fl_tap_valid", 32'(tap4_valid),  32'b1101);
        check("fl_tap_data",  32'(tap4_data),   32'h31323233);
`ifdef HS_DPATH_SFR_OCC_CNT_EN
        check("fl_occ", 32'(occ4), 3);
`endif
        next_cycle();
        flush4      = 1'b0;
        s4_if.valid = 1'b0;
        mid();
        check("post_fl_tap_valid", 32'(tap4_valid),  0);
        check("post_fl_tap_data",  32'(tap4_data),   32'h31323233);
        check("post_fl_s_ready",   32'(s4_if.ready), 1);
`ifdef HS_DPATH_SFR_OCC_CNT_EN
        check("post_fl_occ", 32'(occ4), 0);
`endif
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            mid();
            check("post_fl_m_valid", 32'(m4_if.valid), 0);
        end
        next_cycle();

        // ---------------- LATENCY=1: m_ready 1,0,1 ----------------
        s1_if.valid = 1'b1;
        s1_if.data  = 8'h51;
        m1_if.ready = 1'b0;
        mid();
        check("l1_prime_s_ready", 32'(s1_if.ready), 1);
        next_cycle();
        mr_seq = 3'b101;
        d_seq  = '{8'h52, 8'h53, 8'h53};
        n_in   = 0;
        n_out  = 0;
        for (int w = 0; w < 3; w++) begin
            s1_if.valid = 1'b1;
            s1_if.data  = d_seq[w];
            m1_if.ready = mr_seq[w];
            mid();
            if (w == 1) check("l1_stall_s_ready", 32'(s1_if.ready), 0);
            if (m1_if.valid && m1_if.ready) begin
                check("l1_out_data", 32'(m1_if.data), 32'(8'h51 + n_out));
                n_out++;
            end
            if (s1_if.valid && s1_if.ready) n_in++;
            next_cycle();
        end
        check("l1_in_xfers",  32'(n_in),  2);
        check("l1_out_xfers", 32'(n_out), 2);

        // ---------------- LATENCY=1: reset mid-stream ----------------
        sreset      = 1'b1;
        s1_if.valid = 1'b1;
        s1_if.data  = 8'h54;
        m1_if.ready = 1'b0;
        mid();
        check("l1_pre_rst_m_valid", 32'(m1_if.valid), 1);
        check("l1_pre_rst_m_data",  32'(m1_if.data),  32'h53);
        next_cycle();
        sreset      = 1'b0;
        s1_if.valid = 1'b0;
        mid();
        check("l1_rst_m_valid", 32'(m1_if.valid), 0);
        check("l1_rst_m_data",  32'(m1_if.data),  32'h3C);
        check("l1_rst_s_ready", 32'(s1_if.ready), 1);
`ifdef HS_DPATH_SFR_OCC_CNT_EN
        check("l1_rst_occ", 32'(occ1), 0);
`endif
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_hs_dpath_sfr_elastic_tap

// File: doc/hs_dpath_sfr_elastic_tap.md
Name: hs_dpath_sfr_elastic_tap

Overview:
- Parametrised elastic shift register: LATENCY stages, valid/ready handshake on both ends, bubble collapsing, tapped per-stage data and valid.
- Successor to the fixed clock-enable tapped shift register; replaces the per-stage enable vector with self-timed stage advance.
- Sits in datapath pipelines that need fixed nominal latency plus downstream backpressure.

Parameters:
- DATA_TYPE, logic, stage payload type (any packed type).
- RESET_VALUE, '0, payload value of every stage after reset.
- LATENCY, 2, number of stages (1..1024); nominal din-to-dout latency in cycles.
- CHANNELS, 1, independent lanes sharing one handshake; payload is DATA_TYPE per lane.

Ports:
- clk  in  1  clock, all logic on rising edge.
- sreset  in  1  synchronous reset, active-high.
- flush  in  1  synchronous clear of all stage valids.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  upstream may transfer this cycle.
- s_data  in  CHANNELS x DATA_TYPE  upstream payload.
- m_valid  out  1  output stage holds a beat.
- m_ready  in  1  downstream accepts.
- m_data  out  CHANNELS x DATA_TYPE  output stage payload (= tap_data[LATENCY-1]).
- tap_valid  out  LATENCY  per-stage valid.
- tap_data  out  LATENCY x CHANNELS x DATA_TYPE  per-stage payload.

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high (sreset). sreset has priority over everything.
- Reset values: all stage valids 0; all stage payloads RESET_VALUE; so m_valid=0, tap_valid=0, s_ready=1 after reset.
- Stage state: vld[i], dat[i], i=0..LATENCY-1; stage 0 fed from s_*, stage i fed from stage i-1.
- Advance chain (combinational):
  - adv[LATENCY-1] = !vld[LATENCY-1] | m_ready.
  - adv[i] = !vld[i] | adv[i+1].
- Stage update when adv[i]: vld[i] <= upstream valid; dat[i] <= upstream data only if upstream valid (bubbles do not toggle payload).
- Stage hold: when !adv[i], the stage holds.
- Ready: s_ready = adv[0] & !flush.
- Transfer rules: input transfer = s_valid & s_ready; output transfer = m_valid & m_ready.
- Latency: with m_ready held 1, a beat accepted in cycle t appears on m_valid at cycle t+LATENCY.
- Bubble collapse: an empty stage accepts even when downstream is stalled. Up to LATENCY beats can be held with m_ready=0; s_ready drops only when all stages are valid.
- Full: all vld=1 and m_ready=0 -> s_ready=0; no stage changes.
- Full with m_ready=1: whole chain advances; s_ready=1; simultaneous in/out allowed; throughput one beat per cycle.
- Empty: m_valid=0; m_data holds last payload (not cleared).
- flush:
  - All vld <= 0 next cycle; payloads untouched.
  - s_ready=0 during flush, so no beat is lost silently.
  - An output transfer in the flush cycle still completes.
- sreset mid-operation: all in-flight beats dropped; payloads return to RESET_VALUE.
- LATENCY=1: single stage; s_ready = !vld[0] | m_ready.
- Timing: the ready chain is combinational through all stages; the integrator is responsible for depth.

Optional Feature:
- Macro: HS_DPATH_SFR_OCC_CNT_EN.
- Defined:
  - Extra output occ_cnt, width $clog2(LATENCY+1), registered count of valid stages.
  - Update: +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither.
  - flush or sreset -> 0.
  - Must equal popcount(tap_valid) every cycle (assertion included).
- Undefined: port absent, no counter logic.

Decomposition:
- Package hs_dpath_pkg: hs_dpath_occ_width(latency) function returning $clog2(latency+1); localparam HS_DPATH_SFR_MAX_LATENCY=1024.
- Sub-module hs_dpath_sfr_elastic_stage: one stage.
  - Inputs: clk, sreset, flush, up_valid, up_data, adv.
  - Outputs: vld, dat.
- Top generates LATENCY instances and the advance chain.

Test Plan:
- Reset: sreset=1 two cycles -> m_valid=0, tap_valid=0, s_ready=1, tap_data all RESET_VALUE; occ_cnt=0.
- Streaming: LATENCY=4, m_ready=1, push 0x01..0x10 back-to-back -> first m_valid at cycle 4, outputs 0x01..0x10 in order, s_ready never 0.
- Backpressure: LATENCY=4, m_ready=0, push 6 beats -> s_ready falls after 4th accept. Then m_ready=1 -> beats 1..6 drain in order, one per cycle; occ_cnt peaks at 4.
- Bubble collapse: beats at cycles 0 and 2, m_ready=0 from cycle 3 -> both beats packed in stages 3 and 2 by cycle 5; tap_valid=4'b1100.
- Flush: 3 beats in flight, flush=1 one cycle with s_valid=1 -> s_ready=0 that cycle; tap_valid=0 next cycle; payloads unchanged; no further m_valid.
- Edge: LATENCY=1, m_ready toggling 1,0,1 with continuous s_valid -> exactly 2 transfers on each side; no duplicated or dropped beat; sreset asserted mid-stream -> m_valid=0 next cycle.
